// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule.
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Size 3 falls into the default branch and is therefore checked as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      default:   return |lane;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: sub-word extract with sign/zero
// extension on the load path, and lane merge into an existing word on the store path.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] rd_word_i,
  input  logic [WORD_SIZE-1:0] old_word_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  logic [1:0]           size_i,
  input  logic [1:0]           lane_i,
  input  logic                 unsigned_i,
  output logic [WORD_SIZE-1:0] load_data_o,
  output logic [WORD_SIZE-1:0] merge_data_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s      = rd_word_i[{lane_i, 3'b000} +: 8];
    half_s      = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    load_data_o = rd_word_i;
    case (size_i)
      SIZE_BYTE: load_data_o = unsigned_i ? {{(WORD_SIZE-8){1'b0}}, byte_s}
                                          : {{(WORD_SIZE-8){byte_s[7]}}, byte_s};
      SIZE_HALF: load_data_o = unsigned_i ? {{(WORD_SIZE-16){1'b0}}, half_s}
                                          : {{(WORD_SIZE-16){half_s[15]}}, half_s};
      default:   load_data_o = rd_word_i;
    endcase
  end

  always_comb begin
    merge_data_o = old_word_i;
    case (size_i)
      SIZE_BYTE: merge_data_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      SIZE_HALF: merge_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default:   merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed memory with combinational
// read: one outstanding request, read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [31:0]          req_addr_i,
  input  logic [WORD_SIZE-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WORD_SIZE-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  output logic                 mem_wen_o,
  input  logic [WORD_SIZE-1:0] mem_data_i
);

  lsu_state_e           state_q, state_d;
  logic                 we_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [1:0]           lane_q;
  logic [ADDR_SIZE-1:0] waddr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] word_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 err_q;

  logic                 accept;
  logic                 req_mis;
  logic [WORD_SIZE-1:0] load_data;
  logic [WORD_SIZE-1:0] merge_data;
  logic                 unused_addr_hi;

  // Upper address bits beyond the memory size are deliberately dropped (wrap).
  assign unused_addr_hi = ^req_addr_i[31:ADDR_SIZE+2];

  assign accept  = req_valid_i && (state_q == ST_IDLE);
  assign req_mis = misaligned(req_size_i, req_addr_i[1:0]);

  lsu_lane_align #(
    .WORD_SIZE (WORD_SIZE)
  ) u_lane_align (
    .rd_word_i    (mem_data_i),
    .old_word_i   (word_q),
    .wdata_i      (wdata_q),
    .size_i       (size_q),
    .lane_i       (lane_q),
    .unsigned_i   (uns_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      waddr_q <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        lane_q  <= req_addr_i[1:0];
        waddr_q <= req_addr_i[ADDR_SIZE+1:2];
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
        err_q   <= req_mis;
      end
      if (state_q == ST_READ) begin
        word_q <= mem_data_i;
        if (!we_q) rdata_q <= load_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_wen_o   = 1'b0;
    mem_data_o  = '0;
    mem_addr_o  = waddr_q;
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (req_mis)                      state_d = ST_RESP;
          else if (req_we_i && req_size_i[1]) state_d = ST_WRITE;
          else                              state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        mem_wen_o  = 1'b1;
        mem_data_o = merge_data;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic against
// an array-based memory model with arithmetic lane handling.
module tb_load_store_unit;

  localparam int AW = 5;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req_valid, req_ready, req_we, req_uns;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_wen;
  logic          mem_load;

  logic [31:0]   mem     [NW];
  logic [31:0]   ref_mem [NW];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_SIZE(AW), .WORD_SIZE(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_wen_o      (mem_wen),
    .mem_data_i     (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < NW; k++) mem[k] <= 32'(k);
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lane);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lane))) & 32'hFF;
    h = (w >> (16 * int'(lane[1]))) & 32'hFFFF;
    if (size == 2'd0) return (!uns && b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
    if (size == 2'd1) return (!uns && h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
    return w;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] m;
    if (size == 2'd0) begin
      m = 32'hFF << (8 * int'(lane));
      return (old & ~m) | ((wd & 32'hFF) << (8 * int'(lane)));
    end
    if (size == 2'd1) begin
      m = 32'hFFFF << (16 * int'(lane[1]));
      return (old & ~m) | ((wd & 32'hFFFF) << (16 * int'(lane[1])));
    end
    return wd;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request from a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      output logic [31:0] got);
    int          w, k, wen_cnt, wen_k, exp_lat;
    logic        mis, got_v;
    logic [31:0] exp_rdata, new_word, wen_data, wen_addr;
    w        = int'(addr[AW+1:2]);
    mis      = (size == 2'd1) ? addr[0] : (size == 2'd0) ? 1'b0 : (addr[1:0] != 2'd0);
    exp_lat  = mis ? 1 : (!we ? 2 : (size[1] ? 2 : 3));
    exp_rdata = (!we && !mis) ? model_load(ref_mem[w], size, uns, addr[1:0]) : 32'd0;
    new_word = model_store(ref_mem[w], size, addr[1:0], wdata);

    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = (hold == 0);
    chk("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
    req_uns = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;

    k = 0; got_v = 1'b0; wen_cnt = 0; wen_k = 0; wen_data = 0; wen_addr = 0;
    while (k < 12 && !got_v) begin
      @(negedge clk);
      k++;
      if (mem_wen) begin
        wen_cnt++; wen_k = k; wen_data = mem_wdata; wen_addr = 32'(mem_addr);
      end
      got_v = rsp_valid;
    end
    chk("latency", 32'(k), 32'(exp_lat));
    if (!got_v) begin
      chk("rsp_seen", 32'(got_v), 32'd1);
      got = 32'd0;
      do_reset();
      return;
    end
    got = rsp_rdata;
    chk("rdata", rsp_rdata, exp_rdata);
    chk("err", 32'(rsp_err), 32'(mis));
    chk("ready_busy", 32'(req_ready), 32'd0);
    chk("wen_count", 32'(wen_cnt), (we && !mis) ? 32'd1 : 32'd0);
    if (we && !mis) begin
      chk("wen_cycle", 32'(wen_k), 32'(exp_lat - 1));
      chk("wen_addr", wen_addr, 32'(w));
      chk("wen_data", wen_data, new_word);
      ref_mem[w] = new_word;
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rdata);
      chk("hold_err", 32'(rsp_err), 32'(mis));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_wen", 32'(mem_wen), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    int          k;
    rst_ni = 1'b0; mem_load = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'(i);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    mem_load = 1'b0;
    rst_ni   = 1'b1;
    @(negedge clk);

    xact(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, 0, got);
    chk("ld_word_0C", got, 32'h0000_0003);
    xact(1'b1, 2'd2, 1'b0, 32'h04, 32'h80FF_7F01, 0, got);
    xact(1'b0, 2'd0, 1'b0, 32'h05, 32'd0, 0, got);
    chk("ld_sbyte_05", got, 32'h0000_007F);
    xact(1'b0, 2'd0, 1'b0, 32'h07, 32'd0, 0, got);
    chk("ld_sbyte_07", got, 32'hFFFF_FF80);
    xact(1'b0, 2'd0, 1'b1, 32'h07, 32'd0, 0, got);
    chk("ld_ubyte_07", got, 32'h0000_0080);
    xact(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_BEEF, 0, got);
    chk("st_half_mem", mem[2], 32'hBEEF_0002);
    xact(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 0, got);
    chk("ld_after_half", got, 32'hBEEF_0002);
    xact(1'b1, 2'd2, 1'b0, 32'h06, 32'hDEAD_BEEF, 0, got);
    chk("mis_mem1", mem[1], 32'h80FF_7F01);
    xact(1'b0, 2'd1, 1'b0, 32'h05, 32'd0, 0, got);
    xact(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, 5, got);
    xact(1'b0, 2'd1, 1'b0, 32'h06, 32'd0, 0, got);
    chk("ld_shalf_06", got, 32'hFFFF_80FF);

    // Reset arriving while a sub-word store is in its write cycle
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h0000_00AA; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (k < 6 && !mem_wen) begin
      @(negedge clk);
      k++;
    end
    chk("rst_wen_seen", 32'(mem_wen), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_wen_drop", 32'(mem_wen), 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_after_ready", 32'(req_ready), 32'd1);
    chk("rst_after_valid", 32'(rsp_valid), 32'd0);
    chk("rst_word_kept", mem[5], ref_mem[5]);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int          h;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'h7F;
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, h, got);
    end

    for (int i = 0; i < NW; i++) chk($sformatf("mem_final[%0d]", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline's execute stage and the word-addressed memory block.
- Accepts byte-addressed load/store requests over a valid/ready handshake and drives the memory's address, write-data and write-enable.
- Performs read-modify-write for byte and halfword stores, and sign- or zero-extension for sub-word loads.
- Returns one response per request, with an error flag for misaligned accesses.

Parameters:
- ADDR_SIZE, 5: memory word-address width; memory holds 2**ADDR_SIZE words.
- WORD_SIZE, 32: data width; fixed at 32 for byte-lane logic.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  access size: 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- req_unsigned_i  in  1  zero-extend sub-word loads; 0 = sign-extend.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  WORD_SIZE  store data, right-justified.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts the response.
- rsp_rdata_o  out  WORD_SIZE  load result; 0 for stores and errors.
- rsp_err_o  out  1  misaligned access; no memory side effect.
- mem_addr_o  out  ADDR_SIZE  memory word address.
- mem_data_o  out  WORD_SIZE  memory write data.
- mem_wen_o  out  1  memory write enable.
- mem_data_i  in  WORD_SIZE  memory combinational read data.

Behaviour:
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_wen_o=0, mem_addr_o=0, mem_data_o=0. All internal request registers clear to 0.
- Address mapping:
  - Word address = req_addr_i[ADDR_SIZE+1:2]; higher address bits are ignored, so addresses wrap.
  - Byte lane = req_addr_i[1:0]; little-endian, lane 0 = bits 7:0.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte is always aligned.
- Handshake:
  - A request is accepted when req_valid_i and req_ready_o are both high at a clock edge.
  - req_ready_o is high only in IDLE; one request is outstanding at a time.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE, on accept, by request type:
    - misaligned -> RESP with err=1;
    - load -> READ;
    - word store -> WRITE;
    - byte/halfword store -> READ.
  - READ:
    - mem_addr_o is held at the latched word address.
    - mem_data_i is captured into an internal word register.
    - Load -> RESP, with the extracted and extended lane loaded into rsp_rdata_o.
    - Sub-word store -> WRITE.
  - WRITE:
    - mem_wen_o=1 for exactly this one cycle.
    - mem_data_o = the captured word with the target byte/halfword lanes replaced by req_wdata_i[7:0] or [15:0]; for a word store it is req_wdata_i.
    - Next state RESP.
  - RESP:
    - rsp_valid_o=1; hold rsp_rdata_o and rsp_err_o stable.
    - Return to IDLE on rsp_ready_i.
    - rsp_valid_o does not drop combinationally.
- Latency, counted from the accept edge T; earliest rsp_valid_o rising edge:
  - misaligned: T+1;
  - load: T+2;
  - word store: T+2;
  - sub-word store: T+3.
  - The next accept is no earlier than the edge after the response handshake, i.e. no back-to-back bypass.
- Extension: byte and halfword loads use sign-extension unless req_unsigned_i=1; word loads are unaffected by the flag.
- mem_wen_o is 0 in every state except WRITE; erroneous requests never touch memory.
- Backpressure: if rsp_ready_i is low, stay in RESP indefinitely with outputs stable.
- Asynchronous reset in any state, including mid-WRITE, forces mem_wen_o=0 and returns to IDLE immediately. The in-flight request is dropped with no response.
- req_* inputs are sampled only at the accept edge; changes afterwards are ignored.

Decomposition:
- Shared package holds:
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - FSM state encoding;
  - function for the misalignment check.
- One natural sub-module, lsu_lane_align, which is purely combinational and has two functions:
  - byte/halfword extract with sign/zero extension (load path);
  - lane merge (store path).

Test Plan:
- Memory preloaded with mem[k]=k; load word at addr 0x0C, rsp_ready_i=1 -> rsp_valid_o at T+2, rsp_rdata_o=0x00000003, err=0.
- Memory word 1 = 0x80FF7F01. Byte loads:
  - signed byte load at addr 0x05 -> 0x0000007F;
  - signed byte load at addr 0x07 -> 0xFFFFFF80;
  - unsigned byte load at addr 0x07 -> 0x00000080.
- Halfword store 0xBEEF to addr 0x0A with word 2 = 0x00000002 -> a single mem_wen_o pulse at T+2 with mem_data_o=0xBEEF0002; response at T+3; a subsequent word load from addr 0x08 returns 0xBEEF0002.
- Word store at addr 0x06 -> rsp_err_o=1 at T+1; mem_wen_o is never asserted; memory is unchanged.
- Hold rsp_ready_i=0 for 5 cycles after a load -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o=0. On release, a new request is accepted on the following edge.
- Assert rst_ni low during WRITE of a sub-word store -> mem_wen_o=0 in the same cycle; after release req_ready_o=1, rsp_valid_o=0, and the target word is unmodified.
